fb_arbiter: RTL and testbench
=============================

# fb_arbiter

Arbiter and sequencer for the single-port framebuffer SRAM shared by the VGA scan-out reader and the game-logic draw writer. It sits between the pixel timing path (h_out/v_out/pixel_data generation) and the framebuffer memory. It gives the reader priority during active video, gives the writer priority during blanking, and bounds writer starvation. All memory commands are registered, with fixed read latency, so scan-out timing stays deterministic.

## Interface
Parameters:
- ADDR_W, 15, framebuffer address width
- DATA_W, 8, pixel word width
- STARVE_LIMIT, 8, cycles a pending write may wait before it is forced through (range 1–255)

Ports:
- clk  in  1  system clock; all logic on posedge
- nRst  in  1  asynchronous, active-low reset
- blank  in  1  high during horizontal or vertical blanking
- rd_req  in  1  single-cycle read request from scan-out (never held)
- rd_addr  in  ADDR_W  read address, valid with rd_req
- rd_data  out  DATA_W  read data, valid with rd_valid
- rd_valid  out  1  one-cycle pulse, 3 cycles after the accepted rd_req
- rd_drop  out  1  one-cycle pulse, 1 cycle after a rd_req that lost arbitration
- wr_req  in  1  write request; held with stable wr_addr/wr_data until wr_ack
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_ack  out  1  one-cycle pulse on the cycle the write command is issued
- mem_en  out  1  memory command strobe
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after a read command
- drop_count  out  16  saturating count of dropped reads (see Configuration)

## Operation
- Arbitration is evaluated every cycle N on sampled inputs. The winner's command appears on mem_* in cycle N+1.
- Writer eligibility: wr_req=1, and the writer was not acked in cycle N. The one-cycle cooldown prevents a double write while the writer sees wr_ack and deasserts wr_req.
- Priority when both requests are present:
  - If starve_cnt ≥ STARVE_LIMIT, the writer wins.
  - Otherwise, if blank=0, the reader wins.
  - Otherwise (blank=1), the writer wins.
- A single requester always wins. With no requests, mem_en=0 in N+1.
- Losing rd_req: the read is discarded, and rd_drop pulses in N+1. Reads are never queued.
- Losing or ineligible wr_req: no action; the writer keeps holding.
- starve_cnt (8-bit):
  - Increments each cycle an eligible wr_req loses.
  - Clears to 0 when the writer wins.
  - Holds while wr_req=0.
  - Saturates at 255.
- FSM states:
  - IDLE: no command was issued last cycle.
  - RD: a read command is on the bus.
  - WR: a write command is on the bus; wr_ack=1; the writer is ineligible this cycle.
  - The next state is chosen purely by the arbitration result; any state can go to any state.
- Read pipeline:
  - Cycle N: rd_req accepted.
  - N+1: mem_en=1, mem_we=0, mem_addr=rd_addr.
  - N+2: mem_rdata valid.
  - N+3: rd_data registered, rd_valid=1.
- Back-to-back reads every cycle are supported at full throughput.
- mem_addr and mem_wdata hold their last values when mem_en=0.

## Timing
- Reset values:
  - rd_data=0, rd_valid=0, rd_drop=0, wr_ack=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - drop_count=0, starve_cnt=0, FSM=IDLE.
- Reset asserted mid-operation: the in-flight read pipeline is flushed and no rd_valid follows. A write whose command has already been issued is still acked if reset has not yet asserted.
- Read latency: 3 cycles, fixed and independent of writer activity.
- Write latency: at least 1 cycle from eligible request to wr_ack.
- Maximum write wait: STARVE_LIMIT+1 cycles during active video with continuous reads.
- Blank edges take effect in the cycle they are sampled; no pipelining of blank.

## Configuration
- FB_ARB_STATS_EN defined:
  - drop_count increments by 1 on every rd_drop pulse and saturates at 16'hFFFF.
  - It is cleared only by reset.
- Not defined: drop_count is tied to 0 and the counter logic is not synthesized. All other behaviour is identical.

## Test plan
- Reset: hold nRst=0 for 2 cycles, release → all outputs 0 and FSM idle. Assert nRst=0 with a read 1 cycle in flight → no rd_valid afterwards.
- Read latency: blank=0, rd_req pulses at addrs 0x0010..0x0013 on consecutive cycles; memory returns addr[7:0] → rd_valid on 4 consecutive cycles starting at request+3, rd_data=0x10..0x13.
- Blank priority: blank=1, wr_req held (addr 0x0100, data 0xA5) together with rd_req → wr_ack in N+1, mem_we=1, rd_drop=1. Write asserted exactly once even though wr_req stays high in N+1.
- Starvation: blank=0, continuous rd_req, wr_req held, STARVE_LIMIT=8 → 8 reads issued, then the write is forced through with wr_ack. That cycle's rd_req pulses rd_drop, and reads resume the next cycle.
- Stats: FB_ARB_STATS_EN defined, force 3 drops → drop_count=3. Build without the macro → drop_count stays 0 under the same stimulus.

Source files
------------

// File: rtl/fb_arbiter.sv
// fb_arbiter: single-port framebuffer SRAM arbiter between scan-out reader and draw writer.
// Reader has priority during active video, writer during blanking, and a starvation
// counter forces a waiting write through after STARVE_LIMIT lost cycles.
// Optional macro FB_ARB_STATS_EN enables the saturating dropped-read counter.
module fb_arbiter #(
  parameter int unsigned ADDR_W       = 15,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              blank,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_drop,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       drop_count
);

  localparam int unsigned STARVE_W = 8;
  localparam int unsigned CNT_W    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rd_drop_q, rd_drop_d;
  logic                rd_pend_q;
  logic                rd_valid_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                wr_elig;
  logic                wr_wins;

  // State, command and starvation registers
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_drop_q <= rd_drop_d;
    end
  end

  // Arbitration: writer eligible unless acked this cycle; starvation overrides the reader
  always_comb begin
    state_d   = IDLE;
    starve_d  = starve_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_drop_d = 1'b0;
    wr_elig   = wr_req && (state_q != WR);
    wr_wins   = wr_elig && (!rd_req || blank ||
                            (starve_q >= STARVE_W'(STARVE_LIMIT)));
    if (wr_wins) begin
      state_d   = WR;
      addr_d    = wr_addr;
      wdata_d   = wr_data;
      starve_d  = '0;
      rd_drop_d = rd_req;
    end else if (rd_req) begin
      state_d = RD;
      addr_d  = rd_addr;
      if (wr_elig && (starve_q != {STARVE_W{1'b1}})) begin
        starve_d = starve_q + STARVE_W'(1);
      end
    end
  end

  // Read return pipeline: data valid from memory one cycle after the read command
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      rd_pend_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_pend_q  <= (state_q == RD);
      rd_valid_q <= rd_pend_q;
      if (rd_pend_q) begin
        rd_data_q <= mem_rdata;
      end
    end
  end

  assign mem_en    = (state_q != IDLE);
  assign mem_we    = (state_q == WR);
  assign wr_ack    = (state_q == WR);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rd_drop   = rd_drop_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;

`ifdef FB_ARB_STATS_EN
  logic [CNT_W-1:0] drop_cnt_q;

  // Saturating count of dropped reads, cleared only by reset
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      drop_cnt_q <= '0;
    end else if (rd_drop_q && (drop_cnt_q != {CNT_W{1'b1}})) begin
      drop_cnt_q <= drop_cnt_q + CNT_W'(1);
    end
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = CNT_W'(0);
`endif

endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: randomized and directed checks of fb_arbiter against a rule-level model.
module tb_fb_arbiter;

  localparam int unsigned ADDR_W       = 15;
  localparam int unsigned DATA_W       = 8;
  localparam int unsigned STARVE_LIMIT = 8;
`ifdef FB_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              tb_clk = 1'b0;
  logic              nRst;
  logic              blank;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_drop;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [15:0]       drop_count;

  always #5 tb_clk = ~tb_clk;

  fb_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk       (tb_clk),
    .nRst      (nRst),
    .blank     (blank),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_drop   (rd_drop),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .drop_count(drop_count)
  );

  // Synchronous SRAM: unwritten locations read back addr[7:0]
  bit [7:0] mem  [32768];
  bit       seen [32768];
  always @(posedge tb_clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr]  <= mem_wdata;
        seen[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= seen[mem_addr] ? mem[mem_addr] : mem_addr[7:0];
      end
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: rule-level arbitration plus expected read returns
  typedef struct {
    int       due;
    bit [7:0] data;
  } rd_ret_t;

  rd_ret_t     rq[$];
  bit [7:0]    shadow [32768];
  bit          m_ack;
  int          m_starve;
  int          m_drops;
  int          cyc;
  bit          e_en, e_we, e_ack, e_drop;
  bit [14:0]   e_addr;
  bit [7:0]    e_wdata;

  task automatic model_clear();
    rq.delete();
    m_ack    = 1'b0;
    m_starve = 0;
    m_drops  = 0;
    cyc      = 0;
    e_en     = 1'b0;
    e_we     = 1'b0;
    e_ack    = 1'b0;
    e_drop   = 1'b0;
    e_addr   = '0;
    e_wdata  = '0;
  endtask

  task automatic check_outputs();
    bit exp_rv;
    chk("mem_en", 32'(mem_en), 32'(e_en));
    if (e_en) chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    chk("wr_ack", 32'(wr_ack), 32'(e_ack));
    chk("rd_drop", 32'(rd_drop), 32'(e_drop));
    exp_rv = (rq.size() > 0) && (rq[0].due == cyc);
    chk("rd_valid", 32'(rd_valid), 32'(exp_rv));
    if (exp_rv) begin
      chk("rd_data", 32'(rd_data), 32'(rq[0].data));
      void'(rq.pop_front());
    end
    chk("drop_count", 32'(drop_count), STATS ? 32'(m_drops) : 32'd0);
    if (e_drop && m_drops < 65535) m_drops++;
  endtask

  // Drive one cycle of inputs, advance the model, then check the resulting cycle
  task automatic step(input bit rd, input bit [14:0] ra, input bit wr,
                      input bit [14:0] wa, input bit [7:0] wd, input bit bl);
    bit elig, gw, gr;
    rd_req  = rd;
    rd_addr = ra;
    wr_req  = wr;
    wr_addr = wa;
    wr_data = wd;
    blank   = bl;
    elig = wr && !m_ack;
    gw   = elig && (!rd || bl || (m_starve >= int'(STARVE_LIMIT)));
    gr   = rd && !gw;
    e_drop = rd && gw;
    e_ack  = gw;
    e_en   = gw || gr;
    e_we   = gw;
    if (gw) begin
      e_addr     = wa;
      e_wdata    = wd;
      shadow[wa] = wd;
      m_starve   = 0;
    end else if (gr) begin
      e_addr = ra;
      rq.push_back('{due: cyc + 3, data: shadow[ra]});
      if (elig && m_starve < 255) m_starve++;
    end
    m_ack = e_ack;
    cyc++;
    @(negedge tb_clk);
    check_outputs();
  endtask

  task automatic apply_reset();
    nRst    = 1'b0;
    rd_req  = 1'b0;
    wr_req  = 1'b0;
    blank   = 1'b0;
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    repeat (2) @(negedge tb_clk);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_drop", 32'(rd_drop), 32'd0);
    chk("rst_wr_ack", 32'(wr_ack), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_drop_count", 32'(drop_count), 32'd0);
    nRst = 1'b1;
    model_clear();
  endtask

  initial begin
    bit        w_req;
    bit [14:0] w_addr;
    bit [7:0]  w_data;
    bit        bl;
    for (int i = 0; i < 32768; i++) shadow[i] = 8'(i);
    model_clear();
    apply_reset();

    // Read latency: four back-to-back reads, returns three cycles later
    for (int k = 0; k < 8; k++) begin
      if (k < 4) step(1'b1, 15'(16 + k), 1'b0, '0, '0, 1'b0);
      else       step(1'b0, '0, 1'b0, '0, '0, 1'b0);
      chk("lat_valid", 32'(rd_valid), 32'(k >= 2 && k <= 5));
      if (k >= 2 && k <= 5) chk("lat_data", 32'(rd_data), 32'(16 + k - 2));
    end

    // Blank priority and one-cycle write cooldown
    step(1'b1, 15'h0050, 1'b1, 15'h0100, 8'hA5, 1'b1);
    chk("blank_ack", 32'(wr_ack), 32'd1);
    chk("blank_we", 32'(mem_we), 32'd1);
    chk("blank_drop", 32'(rd_drop), 32'd1);
    step(1'b0, '0, 1'b1, 15'h0100, 8'hA5, 1'b1);
    chk("blank_once", 32'(mem_en), 32'd0);
    step(1'b1, 15'h0100, 1'b0, '0, '0, 1'b1);
    repeat (3) step(1'b0, '0, 1'b0, '0, '0, 1'b0);

    // Starvation: write forced through after STARVE_LIMIT lost cycles
    w_req = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step(1'b1, 15'(32 + i), w_req, 15'h0200, 8'h3C, 1'b0);
      chk("starve_ack", 32'(wr_ack), 32'(i == int'(STARVE_LIMIT)));
      chk("starve_drop", 32'(rd_drop), 32'(i == int'(STARVE_LIMIT)));
      if (m_ack) w_req = 1'b0;
    end
    repeat (3) step(1'b0, '0, 1'b0, '0, '0, 1'b0);

    // Reset with a read in flight: no return afterwards
    step(1'b1, 15'h0005, 1'b0, '0, '0, 1'b0);
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, 1'b0, '0, '0, 1'b0);
      chk("flush_valid", 32'(rd_valid), 32'd0);
    end

    // Stats: three forced drops
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 15'(i), 1'b1, 15'(300 + i), 8'(i + 7), 1'b1);
      step(1'b0, '0, 1'b0, '0, '0, 1'b1);
    end
    repeat (3) step(1'b0, '0, 1'b0, '0, '0, 1'b0);
    chk("stats_drops", 32'(drop_count), STATS ? 32'd3 : 32'd0);

    // Randomized traffic
    w_req  = 1'b0;
    w_addr = '0;
    w_data = '0;
    bl     = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) bl = ~bl;
      if (w_req && m_ack) begin
        if ($urandom_range(0, 1) == 1) begin
          w_addr = 15'($urandom_range(0, 63));
          w_data = 8'($urandom);
        end else begin
          w_req = 1'b0;
        end
      end else if (!w_req && $urandom_range(0, 9) < 3) begin
        w_req  = 1'b1;
        w_addr = 15'($urandom_range(0, 63));
        w_data = 8'($urandom);
      end
      step($urandom_range(0, 9) < 7, 15'($urandom_range(0, 63)),
           w_req, w_addr, w_data, bl);
    end
    repeat (4) step(1'b0, '0, 1'b0, '0, '0, 1'b0);
    chk("tail_queue_empty", 32'(rq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
